// File: rtl/gups_rmw_if.sv
// gups_rmw_if -- memory bus between the GUPS update engine and its memory.
//   addr  : request address (master -> slave)
//   dout  : write data (master -> slave)
//   req   : request valid, held until rdy (master -> slave)
//   wr    : 1 = write, 0 = read (master -> slave)
//   din   : read data, valid while rdy is high on a read (slave -> master)
//   rdy   : one-cycle completion pulse (slave -> master)
interface gups_rmw_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] din;
  logic              req;
  logic              wr;
  logic              rdy;

  modport master (
    output addr, dout, req, wr,
    input  din, rdy
  );

  modport slave (
    input  addr, dout, req, wr,
    output din, rdy
  );
endinterface

// File: rtl/gups_rmw.sv
// gups_rmw -- GUPS-style random read-modify-write engine.
// A 32-bit Galois LFSR picks addresses (masked by range); each update reads a word,
// increments it (mode 0) or XORs it with the replicated LFSR value (mode 1) and writes it back.
// Ports:
//   clk, rst (async, active-low)
//   start, count, seed, range, mode : run control, latched on an accepted start in IDLE
//   mem (gups_rmw_if.master)        : addr/dout/req/wr out, din/rdy in
//   busy, done                      : run status; done is a one-cycle pulse in FIN
//   updates                         : completed updates of the current or last run
//   stall_cycles                    : RD/WR cycles with rdy low; real counter only when
//                                     GUPS_STALL_CNT_EN is defined, otherwise tied to 0
module gups_rmw #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic [15:0]       seed,
  input  logic [ADDR_W-1:0] range,
  input  logic              mode,
  gups_rmw_if.master        mem,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  updates,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [2:0] {StIdle, StGen, StRd, StMod, StWr, StFin} state_e;

  localparam logic [31:0] LfsrTaps  = 32'h8020_0003;
  localparam logic [31:0] LfsrReset = 32'h0000_FFFF;

  state_e            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d, lfsr_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d, upd_q, upd_d, upd_inc;
  logic [ADDR_W-1:0] range_q, range_d, addr_q, addr_d, addr_gen;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, dout_q, dout_d, lfsr_rep;

  // Galois step: shift right, fold the taps back in when a 1 falls out.
  assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
  assign upd_inc  = upd_q + CNT_W'(1);

  // Zero-extend (or truncate) the next LFSR value to the address width.
  if (ADDR_W > 32) begin : g_addr_wide
    assign addr_gen = {{(ADDR_W-32){1'b0}}, lfsr_nxt};
  end else if (ADDR_W == 32) begin : g_addr_eq
    assign addr_gen = lfsr_nxt;
  end else begin : g_addr_narrow
    assign addr_gen = lfsr_nxt[ADDR_W-1:0];
  end

  // LFSR repeated (or truncated) to the data width for the XOR update.
  for (genvar g = 0; g < DATA_W; g++) begin : g_rep
    assign lfsr_rep[g] = lfsr_q[g % 32];
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    upd_d   = upd_q;
    range_d = range_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    rdata_d = rdata_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = count;
          range_d = range;
          mode_d  = mode;
          lfsr_d  = {seed, ~seed};
          upd_d   = '0;
          state_d = (count == '0) ? StFin : StGen;
        end
      end
      StGen: begin
        lfsr_d  = lfsr_nxt;
        addr_d  = addr_gen & range_q;
        state_d = StRd;
      end
      StRd: begin
        if (mem.rdy) begin
          rdata_d = mem.din;
          state_d = StMod;
        end
      end
      StMod: begin
        // lfsr_q already holds the value that produced this update's address.
        dout_d  = mode_q ? (rdata_q ^ lfsr_rep) : (rdata_q + DATA_W'(1));
        state_d = StWr;
      end
      StWr: begin
        if (mem.rdy) begin
          upd_d   = upd_inc;
          state_d = (upd_inc == cnt_q) ? StFin : StGen;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      lfsr_q  <= LfsrReset;
      cnt_q   <= '0;
      upd_q   <= '0;
      range_q <= '0;
      addr_q  <= '0;
      mode_q  <= 1'b0;
      rdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      range_q <= range_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
    end
  end

  assign mem.addr = addr_q;
  assign mem.dout = dout_q;
  assign mem.req  = (state_q == StRd) || (state_q == StWr);
  assign mem.wr   = (state_q == StWr);
  assign busy     = (state_q == StGen) || (state_q == StRd) ||
                    (state_q == StMod) || (state_q == StWr);
  assign done     = (state_q == StFin);
  assign updates  = upd_q;

`ifdef GUPS_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == StIdle) && start) begin
      stall_d = '0;
    end else if (mem.req && !mem.rdy && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_gups_rmw.sv
// Self-checking bench for gups_rmw: a behavioural memory/LFSR model answers requests,
// checks every address and write word, and tracks updates and stall cycles.
module tb_gups_rmw;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  count = '0;
  logic [15:0]       seed = '0;
  logic [ADDR_W-1:0] range_v = '0;
  logic              mode = 1'b0;
  logic              busy, done;
  logic [CNT_W-1:0]  updates;
  logic [31:0]       stall_cycles;

  gups_rmw_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  gups_rmw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .count        (count),
    .seed         (seed),
    .range        (range_v),
    .mode         (mode),
    .mem          (mem_if),
    .busy         (busy),
    .done         (done),
    .updates      (updates),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [8192];
  logic [31:0]       m_lfsr = 32'h0000_FFFF;
  logic [ADDR_W-1:0] m_range = '0;
  logic              m_mode = 1'b0;
  int                m_updates = 0;
  int                m_reqs = 0;
  int                m_stall = 0;
  int                done_cnt = 0;
  int                delay = 0;
  bit                stray_en = 1'b0;
  bit                chk_upd = 1'b0;
  int                wait_cnt = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [ADDR_W-1:0] first_addr = '0;
  bit                first_seen = 1'b0;
  logic [DATA_W-1:0] exp_w;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder and per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_if.req) check("busy_with_req", 64'(busy), 64'd1);
      if (done) begin
        check("done_busy", 64'(busy), 64'd0);
        check("done_req", 64'(mem_if.req), 64'd0);
        done_cnt++;
      end
      if (chk_upd) check("updates", 64'(updates), 64'(m_updates));
      if (mem_if.req) begin
        if (wait_cnt == 0) begin
          m_reqs++;
          if (!mem_if.wr) begin
            m_lfsr   = lfsr_step(m_lfsr);
            exp_addr = {32'h0, m_lfsr} & m_range;
            if (!first_seen) begin
              first_addr = mem_if.addr;
              first_seen = 1'b1;
            end
          end
        end
        check("addr", mem_if.addr, exp_addr);
        if (wait_cnt >= delay) begin
          mem_if.rdy = 1'b1;
          wait_cnt   = 0;
          if (!mem_if.wr) begin
            mem_if.din = mem[mem_if.addr[12:0]];
          end else begin
            exp_w = m_mode ? (mem[mem_if.addr[12:0]] ^ {m_lfsr, m_lfsr})
                           : (mem[mem_if.addr[12:0]] + 64'd1);
            check("wdata", mem_if.dout, exp_w);
            mem[mem_if.addr[12:0]] = mem_if.dout;
            m_updates++;
          end
        end else begin
          mem_if.rdy = 1'b0;
          wait_cnt++;
          m_stall++;
        end
      end else begin
        wait_cnt   = 0;
        mem_if.rdy = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end else begin
      wait_cnt   = 0;
      mem_if.rdy = 1'b0;
    end
  end

  task automatic check_stall(input int exp_on);
`ifdef GUPS_STALL_CNT_EN
    check("stall_cycles", 64'(stall_cycles), 64'(exp_on));
`else
    check("stall_cycles", 64'(stall_cycles), 64'd0);
`endif
  endtask

  task automatic kick(input int cnt, input logic [15:0] sd, input logic [ADDR_W-1:0] rg,
                      input logic md, input int dly, input bit stray);
    @(posedge clk); #1;
    delay    = dly;
    stray_en = stray;
    count    = CNT_W'(cnt);
    seed     = sd;
    range_v  = rg;
    mode     = md;
    start    = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    m_lfsr     = {sd, ~sd};
    m_range    = rg;
    m_mode     = md;
    m_updates  = 0;
    m_reqs     = 0;
    m_stall    = 0;
    done_cnt   = 0;
    first_seen = 1'b0;
    chk_upd    = 1'b1;
  endtask

  task automatic run(input int cnt, input logic [15:0] sd, input logic [ADDR_W-1:0] rg,
                     input logic md, input int dly, input bit stray, input bit restart);
    int budget;
    kick(cnt, sd, rg, md, dly, stray);
    budget = cnt * (2 * dly + 6) + 20;
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      start = restart && (i == 5 || i == 6);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    stray_en = 1'b0;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("updates_end", 64'(updates), 64'(cnt));
    check("req_count", 64'(m_reqs), 64'(2 * cnt));
    check("busy_idle", 64'(busy), 64'd0);
    check_stall(m_stall);
  endtask

  initial begin
    logic [DATA_W-1:0] init0;
    bit found;
    mem_if.rdy = 1'b0;
    mem_if.din = '0;
    for (int i = 0; i < 8192; i++) mem[i] = {32'(i) * 32'h9E37_79B9, ~32'(i)};

    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 64'(mem_if.req), 64'd0);
    check("rst_wr", 64'(mem_if.wr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr", mem_if.addr, 64'd0);
    check("rst_dout", mem_if.dout, 64'd0);
    check("rst_updates", 64'(updates), 64'd0);
    check("rst_stall", 64'(stall_cycles), 64'd0);
    rst = 1'b1;

    // Increment run over an 8K window; first address 0x1234EDCB -> 0x893A76E6 & 0x1FFF.
    run(1000, 16'h1234, 64'h1FFF, 1'b0, 2, 1'b0, 1'b0);
    check("first_addr_1234", first_addr, 64'h16E6);
    check_stall(4000);

    // Zero-length run: no requests, immediate done.
    run(0, 16'h5555, 64'hFF, 1'b0, 0, 1'b0, 1'b0);

    // XOR mode with full range; first address is 0x0001FFFE stepped once = 0x0000FFFF.
    run(16, 16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b0, 1'b0);
    check("first_addr_0001", first_addr, 64'h0000_FFFF);

    // range = 0 hammers word 0.
    init0 = mem[0];
    run(8, 16'hBEEF, 64'h0, 1'b0, 1, 1'b0, 1'b0);
    check("mem0_after_8", mem[0], init0 + 64'd8);

    // Three wait cycles per request, ten updates.
    run(10, 16'hACE1, 64'h3FF, 1'b0, 3, 1'b0, 1'b0);
    check_stall(60);

    // Restart attempt mid-run plus stray rdy pulses outside requests.
    run(20, 16'h7777, 64'hFFF, 1'b1, 1, 1'b1, 1'b1);

    // Reset while a write is outstanding.
    kick(50, 16'h2468, 64'h1FF, 1'b0, 2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mem_if.req && mem_if.wr) found = 1'b1;
    end
    check("reached_wr", 64'(found), 64'd1);
    #2;
    chk_upd = 1'b0;
    rst     = 1'b0;
    #1;
    check("mid_rst_req", 64'(mem_if.req), 64'd0);
    check("mid_rst_wr", 64'(mem_if.wr), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_updates", 64'(updates), 64'd0);
    check("mid_rst_stall", 64'(stall_cycles), 64'd0);
    m_updates = 0;
    @(posedge clk); #1;
    rst     = 1'b1;
    chk_upd = 1'b1;
    run(4, 16'h0BAD, 64'h7F, 1'b0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gups_rmw.md
GUPS_RMW -- requirements
Module: gups_rmw

Interface
REQ-001 Parameter DATA_W, default 64, memory data width in bits (>=8).
REQ-002 Parameter ADDR_W, default 64, memory address width in bits (>=8).
REQ-003 Parameter CNT_W, default 32, width of the update count and the progress counters.
REQ-004 clk  input  1  sole clock, rising-edge active.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin a run; sampled only in IDLE.
REQ-007 count  input  CNT_W  number of read-modify-write updates to perform.
REQ-008 seed  input  16  random-sequence seed.
REQ-009 range  input  ADDR_W  address mask.
REQ-010 mode  input  1  update operation: 0 = increment, 1 = XOR with random word.
REQ-011 addr  output  ADDR_W  memory address.
REQ-012 din  input  DATA_W  memory read data, valid in the cycle rdy is high during a read.
REQ-013 dout  output  DATA_W  memory write data.
REQ-014 req  output  1  memory request.
REQ-015 wr  output  1  request type: 1 = write, 0 = read.
REQ-016 rdy  input  1  memory completion, one-cycle pulse.
REQ-017 busy  output  1  high from the accepted start until done.
REQ-018 done  output  1  one-cycle pulse at the end of a run.
REQ-019 updates  output  CNT_W  completed updates in the current or last run.
REQ-020 stall_cycles  output  32  cycles spent waiting for rdy (see Configuration).

Function
REQ-021 FSM states SHALL be IDLE, GEN, RD, MOD, WR and FIN.
REQ-022 IDLE with start=1: latch count, range, mode and seed; load the LFSR with {seed, ~seed}; clear updates; go to FIN if count==0, else to GEN.
REQ-023 LFSR: 32-bit Galois shift right; taps 0x80200003 XORed in when the shifted-out bit is 1; advances exactly once per GEN cycle; never zero.
REQ-024 GEN: addr <= zero-extended LFSR next-value AND latched range; next state RD.
REQ-025 RD: req=1, wr=0; addr held stable; on rdy, capture din and go to MOD.
REQ-026 MOD: single cycle; dout <= captured data + 1 (mode 0, wrapping modulo 2^DATA_W) or captured data XOR replicated LFSR value (mode 1, LFSR truncated or repeated to DATA_W); next state WR.
REQ-027 WR: req=1, wr=1; addr and dout held stable; on rdy, increment updates; go to FIN if the incremented value equals count, else to GEN.
REQ-028 FIN: done=1 for exactly one cycle, busy=0 in that cycle; next state IDLE.
REQ-029 req is low in IDLE, GEN, MOD and FIN; rdy is ignored in those states.
REQ-030 start while busy is ignored; inputs other than din and rdy are not re-sampled mid-run.
REQ-031 Minimum update period with zero-wait memory (rdy in the first req cycle) is 4 cycles (GEN, RD, MOD, WR).
REQ-032 range=0 drives addr=0 on every update; range with all ones in bits [ADDR_W-1:32] still yields zeros there.
REQ-033 busy is high in GEN, RD, MOD and WR; updates holds its value after FIN until the next accepted start.

Reset
REQ-034 rst low forces IDLE immediately (asynchronous) with req=0, wr=0, busy=0, done=0, addr=0, dout=0, updates=0, stall_cycles=0, LFSR=0x0000FFFF.
REQ-035 Reset mid-transaction abandons the transaction; req drops without waiting for rdy.

Configuration
REQ-036 Macro GUPS_STALL_CNT_EN defined: stall_cycles counts, saturating at 0xFFFFFFFF, every cycle in RD or WR in which rdy=0, and clears on an accepted start.
REQ-037 Macro GUPS_STALL_CNT_EN undefined: stall_cycles is tied to 0 and no counter logic is built.

Verification
REQ-038 seed=0x1234, range=0x1FFF, count=1000, mode=0, rdy 2 cycles after each req, 8192-entry model memory -> every write equals model+1, all addresses <=0x1FFF, one done pulse, updates=1000.
REQ-039 count=0, start=1 -> no req, done high 2 cycles after start, updates=0.
REQ-040 mode=1, seed=0x0001, count=16 -> each write equals read data XOR LFSR, checked against a reference LFSR model.
REQ-041 rst driven low while in WR with req=1 -> req=0, busy=0, updates=0 in the same cycle; a new start with count=4 completes 4 updates.
REQ-042 GUPS_STALL_CNT_EN defined, rdy 3 cycles after each req, count=10 -> stall_cycles=60; undefined -> stall_cycles=0.
REQ-043 start pulsed again mid-run and rdy pulsed while req=0 -> no effect; run completes with updates=count.
